// File: rtl/hpdsm_pkg.sv
// Shared types and helpers for the HPDSM channel scheduler.
package hpdsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int tag_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Saturation limits of a w-bit two's-complement value
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/hpdsm_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping modulo NCH.
module hpdsm_rr_arbiter
    import hpdsm_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = tag_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] gnt,
    output logic [CHW-1:0] idx,
    output logic           any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!any && req[(int'(ptr) + i) % NCH]) begin
                gnt[(int'(ptr) + i) % NCH] = 1'b1;
                idx = CHW'((int'(ptr) + i) % NCH);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpdsm_channel_sched.sv
// Time-multiplexed HPDSM base-filter accumulator shared by NCH round-robin streams.
// Optional saturation instead of wrap: define HPDSM_SCHED_SAT_EN.
module hpdsm_channel_sched
    import hpdsm_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int CHW   = tag_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CHW-1:0]       out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

`ifdef HPDSM_SCHED_SAT_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

    state_t                  state, state_next;
    logic [CHW-1:0]          rr_ptr;
    logic [NCH-1:0]          grant;
    logic [CHW-1:0]          grant_idx;
    logic                    grant_any;
    logic                    take;
    logic signed [WIDTH-1:0] x_p0;
    logic [CHW-1:0]          ch_p0;
    logic signed [WIDTH-1:0] acc [NCH];
    logic signed [WIDTH-1:0] sum_p1;

    function automatic logic signed [WIDTH-1:0] base_sum(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] a
    );
        logic signed [WIDTH-1:0] half;
`ifdef HPDSM_SCHED_SAT_EN
        logic signed [WIDTH:0] wide;
        half = x >>> 1;
        wide = {half[WIDTH-1], half} + {a[WIDTH-1], a};
        if (wide[WIDTH] != wide[WIDTH-1])
            return wide[WIDTH] ? SAT_MIN : SAT_MAX;
        return wide[WIDTH-1:0];
`else
        half = x >>> 1;
        return half + a;
`endif
    endfunction

    function automatic logic [CHW-1:0] next_ptr(input logic [CHW-1:0] g);
        return (int'(g) == NCH - 1) ? '0 : g + CHW'(1);
    endfunction

    hpdsm_rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .req (in_valid),
        .ptr (rr_ptr),
        .gnt (grant),
        .idx (grant_idx),
        .any (grant_any)
    );

    assign take     = (state == IDLE) && grant_any;
    assign in_ready = (rst && state == IDLE) ? grant : '0;
    assign sum_p1   = base_sum(x_p0, acc[ch_p0]);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = CALC;
            CALC:    state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            x_p0      <= '0;
            ch_p0     <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < NCH; k++) acc[k] <= '0;
        end else begin
            state <= state_next;
            // p0: capture the granted sample
            if (take) begin
                x_p0   <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                ch_p0  <= grant_idx;
                rr_ptr <= next_ptr(grant_idx);
            end
            // p1: accumulate and publish
            if (state == CALC) begin
                acc[ch_p0] <= sum_p1;
                out_data   <= sum_p1;
                out_ch     <= ch_p0;
                out_valid  <= 1'b1;
            end
            if (state == HOLD && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hpdsm_channel_sched.sv
// Bench for hpdsm_channel_sched (WIDTH=16, NCH=4); honours HPDSM_SCHED_SAT_EN.
module tb_hpdsm_channel_sched;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] macc [N];
    int          mptr;

    always #5 clk = ~clk;

    hpdsm_channel_sched #(.WIDTH(W), .NCH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: y = (x >> 1, arithmetic) + acc, wrapped or clamped to 16-bit range
    function automatic logic [15:0] model_sum(input logic [15:0] x, input logic [15:0] a);
        int xs, as, s;
        xs = int'($signed(x));
        as = int'($signed(a));
        s  = (xs >>> 1) + as;
`ifdef HPDSM_SCHED_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        for (int j = 0; j < N; j++)
            if (v[(ptr + j) % N]) return (ptr + j) % N;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) macc[k] = 16'h0;
        mptr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        model_clear();
    endtask

    // Presents one sample and waits (bounded) until the edge that accepts it.
    task automatic send(input int ch, input logic [15:0] data, output bit ok);
        in_data[ch*W +: W] = data;
        in_valid[ch] = 1'b1;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (in_ready[ch]) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        in_valid[ch] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = '1;
        in_data = {$urandom, $urandom};
        out_ready = 1'b0;
        #3;
        n_tests++; if (in_ready !== 4'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        n_tests++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
        step();
        in_valid = '0;
        rst = 1'b1;
        step();
        n_tests++; if (in_ready !== 4'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 0000", in_ready); end
        model_clear();
    endtask

    task automatic test_basic();
        int          chs [4]  = '{0, 0, 1, 0};
        logic [15:0] din [4]  = '{16'h0004, 16'h0004, 16'hFFFC, 16'h0000};
        logic [15:0] dexp [4] = '{16'h0002, 16'h0004, 16'hFFFE, 16'h0004};
        bit ok;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            send(chs[t], din[t], ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_accept[%0d]: got no grant expected grant ch%0d", t, chs[t]); end
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1[%0d]: got out_valid %b expected 0", t, out_valid); end
            step();
            macc[chs[t]] = model_sum(din[t], macc[chs[t]]);
            mptr = (chs[t] + 1) % N;
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency2[%0d]: got out_valid %b expected 1", t, out_valid); end
            n_tests++; if (out_data !== dexp[t]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", t, out_data, dexp[t]); end
            n_tests++; if (out_ch !== 2'(chs[t])) begin n_fail++; $display("FAIL basic_ch[%0d]: got %0d expected %0d", t, out_ch, chs[t]); end
            step();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release[%0d]: got out_valid %b expected 0", t, out_valid); end
        end
    endtask

    task automatic test_all_valid();
        logic [15:0] d [N];
        logic [3:0]  er;
        logic [15:0] ed;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            d[k] = 16'h1000 * 16'(k + 1) + 16'h0022;
            in_data[k*W +: W] = d[k];
        end
        in_valid = '1;
        step();
        rst = 1'b1;
        model_clear();
        #1;
        for (int c = 0; c < 12; c++) begin
            er = (c % 3 == 0) ? 4'(1 << (c / 3)) : 4'b0;
            n_tests++; if (in_ready !== er) begin n_fail++; $display("FAIL rr_ready[c%0d]: got %b expected %b", c, in_ready, er); end
            n_tests++; if (out_valid !== (c % 3 == 2)) begin n_fail++; $display("FAIL rr_valid[c%0d]: got %b expected %b", c, out_valid, (c % 3 == 2)); end
            if (c % 3 == 2) begin
                ed = model_sum(d[c/3], macc[c/3]);
                macc[c/3] = ed;
                n_tests++; if (out_ch !== 2'(c / 3)) begin n_fail++; $display("FAIL rr_ch[c%0d]: got %0d expected %0d", c, out_ch, c / 3); end
                n_tests++; if (out_data !== ed) begin n_fail++; $display("FAIL rr_data[c%0d]: got %h expected %h", c, out_data, ed); end
            end
            if (c == 11) in_valid = '0;
            step();
        end
        mptr = 0;
    endtask

    task automatic test_hold_stall();
        logic [15:0] e2, e3;
        bit ok;
        out_ready = 1'b0;
        in_data[3*W +: W] = 16'h0300;
        in_valid[3] = 1'b1;
        send(2, 16'h0100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_accept: got no grant expected grant ch2"); end
        e2 = model_sum(16'h0100, macc[2]);
        macc[2] = e2;
        step();
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== e2 || out_ch !== 2'd2) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=%h ch=2", i, out_valid, out_data, out_ch, e2);
            end
            n_tests++; if (in_ready !== 4'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 0000", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        step();
        n_tests++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL stall_next_grant: got %b expected 1000", in_ready); end
        step();
        in_valid[3] = 1'b0;
        e3 = model_sum(16'h0300, macc[3]);
        macc[3] = e3;
        step();
        n_tests++; if (out_valid !== 1'b1 || out_data !== e3 || out_ch !== 2'd3) begin
            n_fail++; $display("FAIL stall_ch3: got v=%b d=%h ch=%0d expected v=1 d=%h ch=3", out_valid, out_data, out_ch, e3);
        end
        step();
        mptr = 0;
    endtask

    task automatic test_overflow();
        logic [15:0] ex [3];
        bit ok;
        ex[0] = 16'h3FFF;
        ex[1] = 16'h7FFE;
`ifdef HPDSM_SCHED_SAT_EN
        ex[2] = 16'h7FFF;
`else
        ex[2] = 16'hBFFD;
`endif
        do_reset();
        for (int t = 0; t < 3; t++) begin
            send(2, 16'h7FFE, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_accept[%0d]: got no grant expected grant ch2", t); end
            step();
            n_tests++; if (out_data !== ex[t] || out_ch !== 2'd2) begin
                n_fail++; $display("FAIL ovf_data[%0d]: got d=%h ch=%0d expected d=%h ch=2", t, out_data, out_ch, ex[t]);
            end
            macc[2] = model_sum(16'h7FFE, macc[2]);
            step();
        end
        mptr = 3;
    endtask

    task automatic test_reset_midop();
        bit ok;
        out_ready = 1'b0;
        send(1, 16'h1234, ok);
        step();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got out_valid %b expected 1", out_valid); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin
            n_fail++; $display("FAIL midrst_drop: got v=%b d=%h expected v=0 d=0000", out_valid, out_data);
        end
        #3;
        rst = 1'b1;
        model_clear();
        step();
        out_ready = 1'b1;
        send(3, 16'h0010, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL midrst_accept: got no grant expected grant ch3"); end
        step();
        n_tests++; if (out_data !== 16'h0008 || out_ch !== 2'd3 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_first: got v=%b d=%h ch=%0d expected v=1 d=0008 ch=3", out_valid, out_data, out_ch);
        end
        macc[3] = 16'h0008;
        mptr = 0;
        step();
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [15:0]  d [N];
        logic [15:0]  px, exp_d;
        logic [N-1:0] er;
        int           mphase, pch, exp_ch, g;
        do_reset();
        v = '0;
        for (int k = 0; k < N; k++) d[k] = 16'h0;
        mphase = 0;
        pch = 0;
        exp_ch = 0;
        exp_d = 16'h0;
        px = 16'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_tests++; if (out_valid !== (mphase == 2)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", cyc, out_valid, (mphase == 2)); end
            if (mphase == 2) begin
                n_tests++; if (out_data !== exp_d || out_ch !== 2'(exp_ch)) begin
                    n_fail++; $display("FAIL rnd_out[%0d]: got d=%h ch=%0d expected d=%h ch=%0d", cyc, out_data, out_ch, exp_d, exp_ch);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (v[k]) begin
                    if ($urandom_range(0, 9) == 0) v[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    v[k] = 1'b1;
                    d[k] = 16'($urandom);
                end
                in_data[k*W +: W] = d[k];
            end
            in_valid = v;
            #1;
            g = model_grant(v, mptr);
            er = (mphase == 0 && g >= 0) ? 4'(1 << g) : 4'b0;
            n_tests++; if (in_ready !== er) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, in_ready, er); end
            case (mphase)
                0: if (g >= 0) begin
                    px = d[g];
                    pch = g;
                    mptr = (g + 1) % N;
                    v[g] = 1'b0;
                    mphase = 1;
                end
                1: begin
                    exp_d = model_sum(px, macc[pch]);
                    macc[pch] = exp_d;
                    exp_ch = pch;
                    mphase = 2;
                end
                default: if (out_ready) mphase = 0;
            endcase
            step();
        end
        in_valid = '0;
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b0;
        in_data = '0;
        in_valid = '0;
        out_ready = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_all_valid();
        test_hold_stall();
        test_overflow();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
